// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side controller for a 1-cycle-latency simple-dual-port block RAM.
// A (base, count) command walks the RAM read port and the returned words are
// emitted as a valid/ready stream. A 2-entry skid buffer absorbs the RAM read
// latency, so the stream sustains one word per cycle while out_ready stays high.
//
// Handshake semantics (both cmd_* and out_*): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer holding valid high
// keeps its payload stable until that edge. cmd_ready does not depend on
// cmd_valid, and out_valid does not depend on out_ready.
module bram_stream_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_base,
    input  logic [ADDRESS_WIDTH:0]   cmd_count,
    output logic [ADDRESS_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0]    dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [1:0]               state_debug
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESS_WIDTH:0]   REM_ONE  = 1;

    state_t                   state_q;
    state_t                   state_next;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH:0]   remaining_q;
    logic [ADDRESS_WIDTH-1:0] raddr_q;
    logic                     inflight_q;
    logic                     inflight_last_q;

    // Skid buffer: entry 0 is always the head presented on out_*.
    logic [1:0]               occ_q;
    logic [DATA_WIDTH-1:0]    data0_q;
    logic [DATA_WIDTH-1:0]    data1_q;
    logic                     last0_q;
    logic                     last1_q;

    logic                     cmd_fire;
    logic                     pop;
    logic                     push;
    logic [2:0]               fill;
    logic                     issue;
    logic                     issue_last;

    // Handshakes, the no-overflow issue rule and the read address presented to the RAM.
    always_comb begin
        cmd_fire   = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        fill       = 3'd0;
        issue      = 1'b0;
        issue_last = 1'b0;
        raddr      = raddr_q;

        cmd_fire = cmd_valid && (state_q == S_IDLE);
        pop      = (occ_q != 2'd0) && out_ready;
        push     = inflight_q;
        // Words that will be buffered after this edge if no new read were issued.
        fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == S_RUN) && (remaining_q != '0) && (fill < 3'd2);
        issue_last = issue && (remaining_q == REM_ONE);
        // A new address only when issuing; otherwise the RAM sees the previous one.
        if (issue) begin
            raddr = addr_q;
        end
    end

    // Next-state logic; a zero-length command is accepted but never leaves IDLE.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire && (cmd_count != '0)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (issue_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last0_q) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Address walker, remaining-word counter and the one-deep in-flight tracker.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            raddr_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            raddr_q         <= raddr;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (cmd_fire) begin
                addr_q      <= cmd_base;
                remaining_q <= cmd_count;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_ONE;
                remaining_q <= remaining_q - REM_ONE;
            end
        end
    end

    // Skid buffer: capture the RAM word one cycle after issue, shift on pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data0_q <= dout;
                        last0_q <= inflight_last_q;
                    end else begin
                        data1_q <= dout;
                        last1_q <= inflight_last_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        data0_q <= dout;
                        last0_q <= inflight_last_q;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= dout;
                        last1_q <= inflight_last_q;
                    end
                end
                default: begin
                    occ_q <= occ_q;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        out_valid   = (occ_q != 2'd0);
        out_data    = data0_q;
        out_last    = last0_q;
        state_debug = state_q;
    end

endmodule
